// File: rtl/sd_read.sv
// sd_read: SPI-mode single-block reader (CMD17 -> R1 -> start token -> 4096 data bits + CRC16).
// Define SD_READ_CRC_CHECK_EN to verify the block CRC16-CCITT before reporting completion.
//   IDLE wait for re | RCMD_PRE latch command | RCMD_SEND shift 48 bits | RCMD_RSPS await R1
//   WAIT_TOKEN await 8'hFE | READ 4096 data bits | READ_CRC 16 CRC bits | PAUSE cs high 16 cycles
//   END rend high until re drops | ERROR rerr sticky until reset
module sd_read #(
    parameter int TOKEN_TIMEOUT = 4096,
    parameter int R1_TIMEOUT    = 128
) (
    input  logic          sdclk,
    input  logic          reset,
    input  logic [31:0]   addr,
    input  logic          re,
    input  logic          dout,
    output logic          cs,
    output logic          din,
    output logic [4095:0] rdata,
    output logic          rend,
    output logic          rerr
);

    typedef enum logic [9:0] {
        IDLE       = 10'b00_0000_0001,
        RCMD_PRE   = 10'b00_0000_0010,
        RCMD_SEND  = 10'b00_0000_0100,
        RCMD_RSPS  = 10'b00_0000_1000,
        WAIT_TOKEN = 10'b00_0001_0000,
        READ       = 10'b00_0010_0000,
        READ_CRC   = 10'b00_0100_0000,
        PAUSE      = 10'b00_1000_0000,
        END        = 10'b01_0000_0000,
        ERROR      = 10'b10_0000_0000
    } state_t;

    localparam logic [15:0] R1_LAST  = 16'(R1_TIMEOUT - 1);
    localparam logic [15:0] TOK_LAST = 16'(TOKEN_TIMEOUT - 1);

    state_t        state_q;
    logic [15:0]   cnt_q;
    logic [2:0]    bcnt_q;
    logic [6:0]    shr_q;
    logic [7:0]    shr_d;
    logic [47:0]   cmd_q;
    logic          din_q;
    logic          cs_q;
    logic          rend_q;
    logic          rerr_q;
    logic [4095:0] rdata_q;
`ifdef SD_READ_CRC_CHECK_EN
    logic [15:0]   crc_q;
    logic [15:0]   crc_d;
    logic [14:0]   crc_rx_q;
    logic [15:0]   crc_rx_d;
`endif

    // Byte assembler shared by R1 and token search; the 8th bit is judged as it arrives.
    assign shr_d = {shr_q, dout};

`ifdef SD_READ_CRC_CHECK_EN
    always_comb begin
        crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ dout) ? 16'h1021 : 16'h0000);
    end
    assign crc_rx_d = {crc_rx_q, dout};
`endif

    always_ff @(posedge sdclk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bcnt_q   <= '0;
            shr_q    <= 7'h7F;
            cs_q     <= 1'b1;
            rend_q   <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
`ifdef SD_READ_CRC_CHECK_EN
            crc_q    <= '0;
            crc_rx_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (re) begin
                        state_q <= RCMD_PRE;
                        cs_q    <= 1'b0;
                    end
                end
                RCMD_PRE: begin
                    state_q <= RCMD_SEND;
                    cnt_q   <= '0;
                    bcnt_q  <= '0;
                    shr_q   <= 7'h7F;
`ifdef SD_READ_CRC_CHECK_EN
                    crc_q   <= '0;
`endif
                end
                RCMD_SEND: begin
                    if (cnt_q == 16'd48) begin
                        state_q <= RCMD_RSPS;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RCMD_RSPS: begin
                    shr_q <= shr_d[6:0];
                    cnt_q <= cnt_q + 16'd1;
                    if (!shr_d[7]) begin
                        cnt_q  <= '0;
                        bcnt_q <= '0;
                        if (shr_d == 8'h00) begin
                            state_q <= WAIT_TOKEN;
                        end else begin
                            state_q <= ERROR;
                            cs_q    <= 1'b1;
                            rerr_q  <= 1'b1;
                        end
                    end else if (shr_d == 8'hFF && cnt_q == R1_LAST) begin
                        state_q <= ERROR;
                        cs_q    <= 1'b1;
                        rerr_q  <= 1'b1;
                    end
                end
                WAIT_TOKEN: begin
                    shr_q  <= shr_d[6:0];
                    bcnt_q <= bcnt_q + 3'd1;
                    cnt_q  <= cnt_q + 16'd1;
                    if (bcnt_q == 3'd7 && shr_d == 8'hFE) begin
                        state_q <= READ;
                        cnt_q   <= '0;
                    end else if (cnt_q == TOK_LAST || (bcnt_q == 3'd7 && shr_d != 8'hFF)) begin
                        state_q <= ERROR;
                        cs_q    <= 1'b1;
                        rerr_q  <= 1'b1;
                    end
                end
                READ: begin
                    rdata_q <= {dout, rdata_q[4095:1]};
`ifdef SD_READ_CRC_CHECK_EN
                    crc_q   <= crc_d;
`endif
                    if (cnt_q == 16'd4095) begin
                        state_q <= READ_CRC;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                READ_CRC: begin
`ifdef SD_READ_CRC_CHECK_EN
                    crc_rx_q <= crc_rx_d[14:0];
`endif
                    if (cnt_q == 16'd15) begin
                        cnt_q   <= '0;
                        cs_q    <= 1'b1;
                        state_q <= PAUSE;
`ifdef SD_READ_CRC_CHECK_EN
                        if (crc_rx_d != crc_q) begin
                            state_q <= ERROR;
                            rerr_q  <= 1'b1;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                PAUSE: begin
                    if (cnt_q == 16'd15) begin
                        state_q <= END;
                        rend_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                END: begin
                    if (!re) begin
                        state_q <= IDLE;
                        rend_q  <= 1'b0;
                    end
                end
                ERROR: begin
                    cs_q   <= 1'b1;
                    rerr_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    cs_q    <= 1'b1;
                end
            endcase
        end
    end

    // Ones are shifted in behind the command so din returns high on the 49th falling edge.
    always_ff @(negedge sdclk or posedge reset) begin
        if (reset) begin
            cmd_q <= '1;
            din_q <= 1'b1;
        end else if (state_q == RCMD_PRE) begin
            cmd_q <= {8'h51, addr, 8'hFF};
            din_q <= 1'b1;
        end else if (state_q == RCMD_SEND) begin
            din_q <= cmd_q[47];
            cmd_q <= {cmd_q[46:0], 1'b1};
        end else begin
            din_q <= 1'b1;
        end
    end

    assign cs    = cs_q;
    assign din   = din_q;
    assign rdata = rdata_q;
    assign rend  = rend_q;
    assign rerr  = rerr_q;

endmodule

// File: tb/tb_sd_read.sv
// Testbench for sd_read: SD card bit-stream model, command capture and a completion scoreboard.
`timescale 1ns/1ps
module tb_sd_read;
    localparam int TOKEN_TIMEOUT = 4096;
    localparam int R1_TIMEOUT    = 128;

    logic          sdclk = 1'b0;
    logic          reset = 1'b1;
    logic          re    = 1'b0;
    logic          dout  = 1'b1;
    logic [31:0]   addr  = '0;
    logic          cs;
    logic          din;
    logic          rend;
    logic          rerr;
    logic [4095:0] rdata;

    sd_read #(.TOKEN_TIMEOUT(TOKEN_TIMEOUT), .R1_TIMEOUT(R1_TIMEOUT)) dut (
        .sdclk(sdclk), .reset(reset), .addr(addr), .re(re), .dout(dout),
        .cs(cs), .din(din), .rdata(rdata), .rend(rend), .rerr(rerr)
    );

    always #5 sdclk = ~sdclk;

    typedef struct {
        bit            err;
        bit            chk_data;
        logic [4095:0] data;
        int            cyc_off;
    } exp_t;

    int            n_pass = 0;
    int            n_total = 0;
    exp_t          exp_q[$];
    logic [47:0]   cmd_exp_q[$];
    bit            stream_q[$];
    bit [7:0]      blk [512];
    logic [4095:0] last_rdata = '0;
    int            cyc = 0;
    int            cap_cyc = 0;
    int            cap_cnt = 0;
    int            capn = 0;
    bit            streaming = 0;
    logic [47:0]   cap = '0;
    exp_t          mon_e;
    logic          prev_rend = 1'b0;
    logic          prev_rerr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_data(input string name, input logic [4095:0] act, input logic [4095:0] exp);
        int first;
        first = 0;
        n_total++;
        if (act === exp) n_pass++;
        else begin
            for (int i = 4095; i >= 0; i--) if (act[i] !== exp[i]) first = i;
            $display("FAIL %s: first differing bit %0d got %b expected %b",
                     name, first, act[first], exp[first]);
        end
    endtask

    // Card model: captures the command once cs is low and din shows its start bit,
    // then plays the prepared response stream one bit per falling edge.
    always @(posedge sdclk or posedge reset) begin
        if (reset) begin
            capn = 0;
            streaming = 0;
        end else begin
            cyc++;
            if (cs) begin
                capn = 0;
                streaming = 0;
            end else if (!streaming && (capn > 0 || din == 1'b0)) begin
                cap = {cap[46:0], din};
                capn++;
                if (capn == 48) begin
                    streaming = 1;
                    cap_cyc = cyc;
                    cap_cnt++;
                    if (cmd_exp_q.size() == 0) chk("unexpected_cmd", {16'h0, cap}, 64'h0);
                    else chk("cmd_bits", {16'h0, cap}, {16'h0, cmd_exp_q.pop_front()});
                end
            end
        end
    end

    always @(negedge sdclk) begin
        if (streaming && stream_q.size() > 0) dout = stream_q.pop_front();
        else dout = 1'b1;
    end

    // Scoreboard monitor: each rising rend/rerr consumes one expected outcome.
    always @(negedge sdclk) begin
        if (!reset && ((rend && !prev_rend) || (rerr && !prev_rerr))) begin
            if (exp_q.size() == 0) chk("unexpected_done", {62'h0, rerr, rend}, 64'h0);
            else begin
                mon_e = exp_q.pop_front();
                chk("done_kind", {62'h0, rerr, rend}, mon_e.err ? 64'h2 : 64'h1);
                chk("cs_high_at_done", {63'h0, cs}, 64'h1);
                chk("din_high_at_done", {63'h0, din}, 64'h1);
                if (mon_e.chk_data) chk_data("rdata", rdata, mon_e.data);
                if (mon_e.cyc_off >= 0)
                    chk("done_cycle", 64'(cyc), 64'(cap_cyc + mon_e.cyc_off));
            end
        end
        prev_rend = rend;
        prev_rerr = rerr;
    end

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) stream_q.push_back(b[i]);
    endtask

    function automatic logic [15:0] crc16_blk();
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int n = 0; n < 512; n++)
            for (int i = 7; i >= 0; i--) begin
                fb = c[15] ^ blk[n][i];
                c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        return c;
    endfunction

    function automatic logic [4095:0] blk_bits();
        logic [4095:0] v;
        for (int k = 0; k < 4096; k++) v[k] = blk[k / 8][7 - (k % 8)];
        return v;
    endfunction

    task automatic build(input int pre, input logic [7:0] r1, input int gap, input bit tok_en,
                         input logic [7:0] tok, input bit data_en, input logic [15:0] crc_xor);
        logic [15:0] c;
        stream_q.delete();
        repeat (pre) push_byte(8'hFF);
        push_byte(r1);
        repeat (gap) push_byte(8'hFF);
        if (tok_en) push_byte(tok);
        if (data_en) begin
            for (int n = 0; n < 512; n++) push_byte(blk[n]);
            c = crc16_blk() ^ crc_xor;
            push_byte(c[15:8]);
            push_byte(c[7:0]);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(rend || rerr) && n < 12000) begin
            @(negedge sdclk);
            n++;
        end
        if (n >= 12000) begin
            n_total++;
            $display("FAIL done_timeout: no rend/rerr after %0d cycles", n);
        end
    endtask

    task automatic run_read(input logic [31:0] a, input bit err, input bit chk_d,
                            input logic [4095:0] d, input int cyc_off);
        exp_t e;
        e.err = err;
        e.chk_data = chk_d;
        e.data = d;
        e.cyc_off = cyc_off;
        cmd_exp_q.push_back({8'h51, a, 8'hFF});
        exp_q.push_back(e);
        @(negedge sdclk);
        addr = a;
        re = 1'b1;
        @(posedge sdclk);
        @(posedge sdclk);
        #1 addr = $urandom;
        wait_done();
        re = 1'b0;
        if (!err) begin
            @(posedge sdclk);
            #1 chk("rend_fall", {63'h0, rend}, 64'h0);
            last_rdata = d;
        end else begin
            repeat (3) @(posedge sdclk);
            #1 chk("rerr_sticky", {63'h0, rerr}, 64'h1);
            chk("rend_low_after_err", {63'h0, rend}, 64'h0);
        end
        @(negedge sdclk);
    endtask

    task automatic do_reset();
        @(negedge sdclk);
        reset = 1'b1;
        re = 1'b0;
        exp_q.delete();
        cmd_exp_q.delete();
        stream_q.delete();
        #1;
        chk("rst_cs", {63'h0, cs}, 64'h1);
        chk("rst_din", {63'h0, din}, 64'h1);
        chk("rst_rend", {63'h0, rend}, 64'h0);
        chk("rst_rerr", {63'h0, rerr}, 64'h0);
        chk_data("rst_rdata", rdata, '0);
        last_rdata = '0;
        #2 reset = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [15:0] flip;
        int          c0;
        int          target;
        int          n;
        repeat (3) @(posedge sdclk);
        do_reset();

        // Reference read: byte n = n, address 0x10
        for (int i = 0; i < 512; i++) blk[i] = 8'(i);
        build(2, 8'h00, 3, 1, 8'hFE, 1, 16'h0000);
        run_read(32'h0000_0010, 0, 1, blk_bits(), -1);

        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 512; i++) blk[i] = 8'($urandom);
            build(int'($urandom_range(1, 4)), 8'h00, int'($urandom_range(0, 5)), 1, 8'hFE, 1, 16'h0000);
            a = $urandom;
            run_read(a, 0, 1, blk_bits(), -1);
        end

        // Data error token right after a good read: rdata must keep the previous block
        build(2, 8'h00, 1, 1, 8'h09, 0, 16'h0000);
        a = $urandom;
        run_read(a, 1, 1, last_rdata, 40);

        do_reset();
        build(2, 8'h04, 0, 0, 8'h00, 0, 16'h0000);
        a = $urandom;
        run_read(a, 1, 1, last_rdata, 24);

        do_reset();
        build(2, 8'h00, 0, 0, 8'h00, 0, 16'h0000);
        a = $urandom;
        run_read(a, 1, 1, last_rdata, 24 + TOKEN_TIMEOUT);

        do_reset();
        for (int i = 0; i < 512; i++) blk[i] = 8'($urandom);
        flip = 16'h0001 << $urandom_range(0, 15);
        build(1, 8'h00, 2, 1, 8'hFE, 1, flip);
        a = $urandom;
`ifdef SD_READ_CRC_CHECK_EN
        run_read(a, 1, 1, blk_bits(), -1);
`else
        run_read(a, 0, 1, blk_bits(), -1);
`endif

        // Reset around data bit 2000, then a fresh read must succeed
        do_reset();
        for (int i = 0; i < 512; i++) blk[i] = 8'($urandom);
        build(2, 8'h00, 1, 1, 8'hFE, 1, 16'h0000);
        a = $urandom;
        cmd_exp_q.push_back({8'h51, a, 8'hFF});
        c0 = cap_cnt;
        @(negedge sdclk);
        addr = a;
        re = 1'b1;
        n = 0;
        while (cap_cnt == c0 && n < 300) begin
            @(negedge sdclk);
            n++;
        end
        if (n >= 300) begin
            n_total++;
            $display("FAIL cmd_capture_timeout: no command after %0d cycles", n);
        end
        target = cap_cyc + 41 + 2000;
        n = 0;
        while (cyc < target && n < 5000) begin
            @(negedge sdclk);
            n++;
        end
        chk("partial_rdata_nonzero", {63'h0, rdata != '0}, 64'h1);
        do_reset();

        for (int i = 0; i < 512; i++) blk[i] = 8'($urandom);
        build(3, 8'h00, 2, 1, 8'hFE, 1, 16'h0000);
        a = $urandom;
        run_read(a, 0, 1, blk_bits(), -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
